// File: rtl/dmem_resp.sv
// Wait-state data memory responder: a req/ack load/store port over a 32-bit word array,
// with word/byte access, window decode, fault reporting and a fixed number of wait cycles.
module dmem_resp #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        is_byte,     // 1 = byte access, 0 = word access
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_q;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] idx;
  logic [31:0]      word_off;
  logic             out_of_window;
  logic             misaligned;
  logic             fault;
  logic [1:0]       lane;
  logic [3:0]       lane_onehot;
  logic [3:0]       wr_lane;
  logic [7:0]       mem_lane [4];
  logic [7:0]       wr_byte  [4];

  // The array is read with the live address at the sampling edge; no write can
  // land between that edge and the access edge, so mem_q is current when used.
  assign rd_idx = IDX_W'((addr - BASE_ADDR) >> 2);

  assign word_off      = (addr_q - BASE_ADDR) >> 2;
  assign idx           = word_off[IDX_W-1:0];
  assign out_of_window = (addr_q < BASE_ADDR) || (word_off >= 32'(DEPTH_WORDS));
  assign misaligned    = !byte_q && (addr_q[1:0] != 2'b00);
  assign fault         = out_of_window || misaligned;
  assign lane          = addr_q[1:0];
  assign lane_onehot   = 4'b0001 << lane;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign mem_lane[gi] = mem_q[gi*8 +: 8];
    assign wr_byte[gi]  = byte_q ? wdata_q[7:0] : wdata_q[gi*8 +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    we_d    = we_q;
    byte_d  = byte_q;
    wdata_d = wdata_q;
    wr_lane = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          byte_d  = is_byte;
          wdata_d = write_data;
          cnt_d   = 4'd0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          if (fault) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else if (we_q) begin
            wr_lane = byte_q ? lane_onehot : 4'b1111;
          end else begin
            rdata_d = byte_q ? {24'h0, mem_lane[lane]} : mem_q;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    byte_q  <= byte_d;
    wdata_q <= wdata_d;
  end

  // A reset edge aborts an in-flight store, so writes are gated by reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE) begin
      mem_q <= mem[rd_idx];
    end
    if (!reset) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_lane[l]) begin
          mem[idx][l*8 +: 8] <= wr_byte[l];
        end
      end
    end
  end

  assign read_data = rdata_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: three instances (different wait/base settings) checked every cycle
// against a transaction-timeline model, plus directed accesses with literal expectations.
module tb_dmem_resp;

  localparam int N     = 3;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       rst_v, req_v, we_v, byte_v, ack_v, err_v, busy_v;
  logic [N-1:0][31:0] addr_v, wd_v, rd_v;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    dmem_resp #(
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (gi == 2 ? 32'h0000_1000 : 32'h0000_0000),
      .WAIT_CYCLES(gi == 0 ? 1 : (gi == 1 ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .reset     (rst_v[gi]),
      .req       (req_v[gi]),
      .we        (we_v[gi]),
      .is_byte   (byte_v[gi]),
      .addr      (addr_v[gi]),
      .write_data(wd_v[gi]),
      .read_data (rd_v[gi]),
      .ack       (ack_v[gi]),
      .err       (err_v[gi]),
      .busy      (busy_v[gi])
    );
  end

  function automatic int wait_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 2) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
    end
  endtask

  // Model: an access sampled at edge s completes at edge s+1+W and frees the port at s+2+W.
  bit          m_act  [N];
  int          m_start[N];
  bit          m_we   [N];
  bit          m_byte [N];
  logic [31:0] m_addr [N];
  logic [31:0] m_wd   [N];
  logic [31:0] m_mem  [N][DEPTH];
  logic [3:0]  m_vld  [N][DEPTH];
  bit          e_ack  [N];
  bit          e_err  [N];
  bit          e_busy [N];
  bit          e_rdk  [N];
  logic [31:0] e_rd   [N];

  task automatic do_access(input int i);
    logic [31:0] off;
    int wi, ln;
    off = m_addr[i] - base_of(i);
    wi  = int'(off >> 2);
    ln  = int'(m_addr[i][1:0]);
    if (m_addr[i] < base_of(i) || (off >> 2) >= DEPTH || (!m_byte[i] && ln != 0)) begin
      e_err[i] = 1'b1;
      e_rd[i]  = 32'h0;
      e_rdk[i] = 1'b1;
    end else if (m_we[i]) begin
      if (m_byte[i]) begin
        m_mem[i][wi] = (m_mem[i][wi] & ~(32'hFF << (8*ln))) | ({24'h0, m_wd[i][7:0]} << (8*ln));
        m_vld[i][wi] = m_vld[i][wi] | (4'b0001 << ln);
      end else begin
        m_mem[i][wi] = m_wd[i];
        m_vld[i][wi] = 4'b1111;
      end
    end else if (m_byte[i]) begin
      e_rd[i]  = (m_mem[i][wi] >> (8*ln)) & 32'hFF;
      e_rdk[i] = m_vld[i][wi][ln];
    end else begin
      e_rd[i]  = m_mem[i][wi];
      e_rdk[i] = (m_vld[i][wi] == 4'b1111);
    end
  endtask

  task automatic model_edge(input int i);
    e_ack[i] = 1'b0;
    e_err[i] = 1'b0;
    if (rst_v[i]) begin
      m_act[i]  = 1'b0;
      e_rd[i]   = 32'h0;
      e_rdk[i]  = 1'b1;
      e_busy[i] = 1'b0;
      return;
    end
    if (m_act[i]) begin
      if (cyc == m_start[i] + 1 + wait_of(i)) begin
        e_ack[i] = 1'b1;
        do_access(i);
      end else if (cyc == m_start[i] + 2 + wait_of(i)) begin
        m_act[i] = 1'b0;
      end
    end else if (req_v[i]) begin
      m_act[i]   = 1'b1;
      m_start[i] = cyc;
      m_we[i]    = we_v[i];
      m_byte[i]  = byte_v[i];
      m_addr[i]  = addr_v[i];
      m_wd[i]    = wd_v[i];
    end
    e_busy[i] = m_act[i];
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_act[i] = 1'b0;
      e_rdk[i] = 1'b0;
      for (int w = 0; w < DEPTH; w++) m_vld[i][w] = 4'b0000;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < N; i++) model_edge(i);
    end
  end

  // Per-cycle compare of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int i = 0; i < N; i++) begin
          chk("ack", i, 32'(ack_v[i]), 32'(e_ack[i]));
          chk("err", i, 32'(err_v[i]), 32'(e_err[i]));
          chk("busy", i, 32'(busy_v[i]), 32'(e_busy[i]));
          if (e_rdk[i]) chk("read_data", i, rd_v[i], e_rd[i]);
        end
      end
    end
  end

  task automatic access(input int i, input bit w, input bit b, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble,
                        output logic [31:0] rd, output bit er, output int lat, output int nbusy);
    int k;
    bit got;
    @(negedge clk);
    we_v[i]   = w;
    byte_v[i] = b;
    addr_v[i] = a;
    wd_v[i]   = d;
    req_v[i]  = 1'b1;
    k     = cyc + 1;
    got   = 1'b0;
    nbusy = 0;
    rd    = 32'h0;
    er    = 1'b0;
    lat   = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (busy_v[i] === 1'b1) nbusy++;
      if (scramble && n == 0) begin
        addr_v[i] = a ^ 32'h4;
        wd_v[i]   = ~d;
      end
      if (ack_v[i] === 1'b1) begin
        got = 1'b1;
        rd  = rd_v[i];
        er  = err_v[i];
        lat = cyc - k;
      end
    end
    req_v[i] = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL ack_timeout inst=%0d addr=%h got=no_ack want=ack", i, a);
    end
  endtask

  logic [31:0] rd;
  bit          er;
  int          lat, nb, nack;

  initial begin
    rst_v  = '1;
    req_v  = '0;
    we_v   = '0;
    byte_v = '0;
    addr_v = '0;
    wd_v   = '0;
    repeat (2) @(negedge clk);
    chk("rst_rd", 0, rd_v[0], 32'h0);
    chk("rst_busy", 0, 32'(busy_v[0]), 32'h0);
    rst_v = '0;

    // Instance 0: WAIT_CYCLES=1, base 0
    access(0, 1, 0, 32'h08, 32'h1234_5678, 0, rd, er, lat, nb);
    chk("st_lat", 0, lat, 2);
    chk("st_err", 0, 32'(er), 0);
    chk("st_busy_cycles", 0, nb, 3);
    @(negedge clk);
    chk("busy_after_done", 0, 32'(busy_v[0]), 0);
    access(0, 0, 0, 32'h08, 32'h0, 0, rd, er, lat, nb);
    chk("ld_word", 0, rd, 32'h1234_5678);
    chk("ld_err", 0, 32'(er), 0);
    chk("ld_lat", 0, lat, 2);

    access(0, 1, 0, 32'h20, 32'hAABB_CCDD, 0, rd, er, lat, nb);
    access(0, 1, 1, 32'h22, 32'hFFFF_FF5A, 0, rd, er, lat, nb);
    chk("stb_err", 0, 32'(er), 0);
    access(0, 0, 0, 32'h20, 32'h0, 0, rd, er, lat, nb);
    chk("lane_word", 0, rd, 32'hAA5A_CCDD);
    access(0, 0, 1, 32'h23, 32'h0, 0, rd, er, lat, nb);
    chk("lane_byte3", 0, rd, 32'h0000_00AA);
    access(0, 0, 1, 32'h21, 32'h0, 0, rd, er, lat, nb);
    chk("lane_byte1", 0, rd, 32'h0000_00CC);
    chk("byte_odd_err", 0, 32'(er), 0);

    access(0, 1, 0, 32'h00, 32'hCAFE_F00D, 0, rd, er, lat, nb);
    access(0, 0, 0, 32'h102, 32'h0, 0, rd, er, lat, nb);
    chk("misalign_err", 0, 32'(er), 1);
    chk("misalign_rd", 0, rd, 32'h0);
    access(0, 1, 0, 32'h100, 32'h0BAD_BAD0, 0, rd, er, lat, nb);
    chk("oow_st_err", 0, 32'(er), 1);
    access(0, 0, 0, 32'h00, 32'h0, 0, rd, er, lat, nb);
    chk("word0_kept", 0, rd, 32'hCAFE_F00D);

    access(0, 1, 0, 32'h30, 32'h5566_7788, 1, rd, er, lat, nb);
    access(0, 0, 0, 32'h30, 32'h0, 0, rd, er, lat, nb);
    chk("captured_st", 0, rd, 32'h5566_7788);
    access(0, 0, 0, 32'h20, 32'h0, 1, rd, er, lat, nb);
    chk("captured_ld", 0, rd, 32'hAA5A_CCDD);

    // Instance 1: WAIT_CYCLES=3, reset in the middle of a store
    access(1, 1, 0, 32'h10, 32'h1111_1111, 0, rd, er, lat, nb);
    chk("w3_lat", 1, lat, 4);
    access(1, 0, 0, 32'h10, 32'h0, 0, rd, er, lat, nb);
    chk("w3_ld", 1, rd, 32'h1111_1111);
    @(negedge clk);
    we_v[1]   = 1'b1;
    byte_v[1] = 1'b0;
    addr_v[1] = 32'h10;
    wd_v[1]   = 32'hDEAD_BEEF;
    req_v[1]  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_v[1] = 1'b1;
    req_v[1] = 1'b0;
    @(negedge clk);
    chk("abort_ack", 1, 32'(ack_v[1]), 0);
    chk("abort_busy", 1, 32'(busy_v[1]), 0);
    chk("abort_rd", 1, rd_v[1], 32'h0);
    rst_v[1] = 1'b0;
    access(1, 0, 0, 32'h10, 32'h0, 0, rd, er, lat, nb);
    chk("abort_no_write", 1, rd, 32'h1111_1111);

    // Instance 2: WAIT_CYCLES=0, base 0x1000
    access(2, 1, 0, 32'h1000, 32'h0F0F_0F0F, 0, rd, er, lat, nb);
    chk("w0_lat", 2, lat, 1);
    access(2, 0, 0, 32'h0FFC, 32'h0, 0, rd, er, lat, nb);
    chk("below_base_err", 2, 32'(er), 1);
    access(2, 0, 0, 32'h1000, 32'h0, 0, rd, er, lat, nb);
    chk("base_ld", 2, rd, 32'h0F0F_0F0F);
    access(2, 1, 0, 32'h1100, 32'h0, 0, rd, er, lat, nb);
    chk("above_win_err", 2, 32'(er), 1);

    @(negedge clk);
    we_v[2]   = 1'b0;
    byte_v[2] = 1'b0;
    addr_v[2] = 32'h1000;
    req_v[2]  = 1'b1;
    nack = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack_v[2] === 1'b1) nack++;
    end
    req_v[2] = 1'b0;
    chk("held_req_acks", 2, nack, 2);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
Wait-state data memory responder for the data_path load/store port. It accepts word and byte requests under a req/ack handshake, decodes the address against a word-array window, and commits or returns data after a programmable number of wait cycles. It replaces the zero-latency bench memory, so that data_path stall and fault handling can be exercised (LDR/STR/LDRB/STRB, out-of-window and misaligned accesses).

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in the array (power of two, at least 4)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned)
WAIT_CYCLES, 1, extra wait cycles per access (0..15)

Ports:
clk  input  1  single clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
req  input  1  access request; held high by the requester until ack
we  input  1  1 = store, 0 = load
byte  input  1  1 = byte access, 0 = word access
addr  input  32  byte address
write_data  input  32  store data; byte stores use only [7:0]
read_data  output  32  registered load data
ack  output  1  one-cycle completion pulse
err  output  1  fault flag; valid only while ack is high
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset:
  - Applies when reset=1 at a rising edge. It takes priority over every other event at that edge.
  - Sets state=IDLE, cnt=0, ack=0, err=0, read_data=0, busy=0.
  - Array contents are not cleared.
  - Reset during WAIT aborts the access; no write is committed.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On an edge with req=1: capture addr, we, byte, write_data into internal registers; set cnt=0; go to WAIT.
  - With req=0: stay in IDLE.
- WAIT:
  - If cnt==WAIT_CYCLES: perform the access at this edge and go to DONE.
  - Otherwise: cnt<=cnt+1.
  - Changes to req and the request inputs during WAIT are ignored; only the captured values are used.
- DONE:
  - ack=1 for exactly one cycle (registered).
  - Always returns to IDLE at the next edge. req is not sampled in DONE.
  - The requester drops req in the cycle in which it sees ack.
- Latency and throughput:
  - Request sampled at edge k → ack high from edge k+1+WAIT_CYCLES to edge k+2+WAIT_CYCLES.
  - Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- Decode:
  - off = addr − BASE_ADDR (32-bit, unsigned); word index = off[31:2].
  - Out of window: addr < BASE_ADDR or index ≥ DEPTH_WORDS.
  - Misaligned: byte=0 and addr[1:0] ≠ 0.
  - Byte accesses are never misaligned.
- Fault (out of window or misaligned):
  - err=1 together with ack.
  - No array write; read_data <= 0.
- Word load: read_data <= array[index].
- Word store: array[index] <= write_data; read_data unchanged.
- Byte lanes are little-endian: lane = addr[1:0], lane 0 = bits [7:0].
- Byte load: read_data <= {24'b0, selected lane byte}.
- Byte store: only the selected lane <= write_data[7:0]; the other three lanes are unchanged; read_data unchanged.
- err=0 on every ack that is not a fault. Between acks, ack=0 and err=0.
- read_data holds its value until the next load ack or fault ack.

Test Plan:
- Reset in the middle of a store: WAIT_CYCLES=3; store word 32'hDEAD_BEEF to addr 0x10; assert reset in the second WAIT cycle; then load 0x10 → loaded value differs from 32'hDEAD_BEEF (pre-written 32'h1111_1111 is returned). After the reset edge: ack=0, busy=0, read_data=0.
- Word round trip with WAIT_CYCLES=1: store 32'h1234_5678 to addr 0x08, then load 0x08 → read_data=32'h1234_5678, err=0. Ack rises exactly 2 edges after the req sampling edge; busy high for 3 cycles.
- Byte lanes:
  - Store 32'hAABB_CCDD to 0x20.
  - Byte store 8'h5A to 0x22.
  - Word load 0x20 → 32'hAA5A_CCDD.
  - Byte load 0x23 → 32'h0000_00AA.
- Faults:
  - Word load at 0x0000_0102 → ack with err=1, read_data=0.
  - Word store at byte 4*DEPTH_WORDS (0x100 for 64 words) → err=1, and array word 0 is unchanged.
  - With BASE_ADDR=0x1000: load at 0x0FFC → err=1.
- Handshake robustness:
  - WAIT_CYCLES=0: ack appears 1 edge after the sampling edge.
  - Change addr and write_data during WAIT → the captured values are used.
  - Hold req high through DONE → the next access is sampled only in the following IDLE cycle, so exactly 2 acks occur over 6 cycles.
